serial_disp_rx: RTL and testbench

SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

---
 rtl/serial_disp_rx.sv | 127 ++++++++++++
 tb/tb_serial_disp_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_disp_rx.sv
// Receiver for a serially shifted 7-segment display frame.
// The pins are asynchronous to clk. A SEG_PEN rising edge commits the shifted frame.
module serial_disp_rx #(
    parameter int unsigned FRAME_BITS  = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_clk,
    input  logic                  seg_sout,
    input  logic                  SEG_PEN,
    input  logic                  seg_clrn,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [6:0]            bit_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StFull} state_e;

    localparam logic [6:0] FrameCnt = FRAME_BITS[6:0];

    state_e                       state_q, state_d;
    logic [3:0][SYNC_STAGES-1:0]  sync_q;
    logic [SYNC_STAGES:0]         fill_q;
    logic                         clk_dly_q, pen_dly_q;
    logic [FRAME_BITS-1:0]        shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]        data_q, data_d;
    logic [6:0]                   cnt_q, cnt_d;
    logic                         ovr_q, ovr_d;
    logic                         fv_q, fv_d;
    logic                         fe_q, fe_d;

    logic [3:0] sync_in;
    logic       s_clk, s_sout, s_pen, s_clr, armed, clk_rise, pen_rise;

    // Clear is synchronized inverted so the all-zero reset state reads as "not clearing".
    assign sync_in  = {~seg_clrn, SEG_PEN, seg_sout, seg_clk};
    assign s_clk    = sync_q[0][SYNC_STAGES-1];
    assign s_sout   = sync_q[1][SYNC_STAGES-1];
    assign s_pen    = sync_q[2][SYNC_STAGES-1];
    assign s_clr    = sync_q[3][SYNC_STAGES-1];
    // Edges are ignored until the chains and delay flops hold real pin values,
    // so a pin already high at reset release does not look like an edge.
    assign armed    = fill_q[SYNC_STAGES];
    assign clk_rise = armed & s_clk & ~clk_dly_q;
    assign pen_rise = armed & s_pen & ~pen_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            fill_q    <= '0;
            clk_dly_q <= 1'b0;
            pen_dly_q <= 1'b0;
            state_q   <= StIdle;
            shreg_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sync_in[i]};
            end
            fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            clk_dly_q <= s_clk;
            pen_dly_q <= s_pen;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
        end
    end

    // A commit takes precedence over a coincident shift, which is dropped.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        if (s_clr) begin
            state_d = StIdle;
            shreg_d = '0;
            data_d  = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (pen_rise) begin
            if (state_q == StFull) begin
                data_d = shreg_q;
            end else begin
                shreg_d = '0;
            end
            cnt_d   = '0;
            state_d = StIdle;
        end else if (clk_rise) begin
            if (state_q == StFull) begin
                ovr_d = 1'b1;
            end else begin
                shreg_d = {shreg_q[FRAME_BITS-2:0], s_sout};
                cnt_d   = cnt_q + 7'd1;
                state_d = (cnt_q + 7'd1 == FrameCnt) ? StFull : StShift;
            end
        end
    end

    always_comb begin
        fv_d = 1'b0;
        fe_d = 1'b0;
        if (!s_clr && pen_rise) begin
            fv_d = (state_q == StFull);
            fe_d = (state_q != StFull);
        end
    end

    assign data_out    = data_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign overrun     = ovr_q;
    assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_serial_disp_rx.sv
// Bench for serial_disp_rx: directed frames plus random frames against a queue-based model.
module tb_serial_disp_rx;

    localparam int unsigned FB = 64;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          rst, seg_clk, seg_sout, SEG_PEN, seg_clrn;
    logic [FB-1:0] data_out;
    logic          frame_valid, frame_err, overrun;
    logic [6:0]    bit_cnt;

    int total = 0;
    int bad   = 0;
    int fv_seen = 0, fe_seen = 0, both_seen = 0;

    // Model state
    bit            bits_q[$];
    logic [FB-1:0] m_data;
    bit            m_ovr;
    int            m_fv, m_fe;

    serial_disp_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_clk     (seg_clk),
        .seg_sout    (seg_sout),
        .SEG_PEN     (SEG_PEN),
        .seg_clrn    (seg_clrn),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
        if (frame_err === 1'b1) fe_seen++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        repeat (6) @(negedge clk);
        chk({tag, ".data"}, data_out, m_data);
        chk({tag, ".cnt"}, 64'(bit_cnt), 64'(bits_q.size()));
        chk({tag, ".ovr"}, 64'(overrun), 64'(m_ovr));
        chk({tag, ".fv"}, 64'(fv_seen), 64'(m_fv));
        chk({tag, ".fe"}, 64'(fe_seen), 64'(m_fe));
    endtask

    task automatic model_bit(input bit b);
        if (bits_q.size() < FB) bits_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic model_commit();
        logic [FB-1:0] v;
        if (bits_q.size() == FB) begin
            v = '0;
            foreach (bits_q[i]) v = {v[FB-2:0], bits_q[i]};
            m_data = v;
            m_fv++;
        end else begin
            m_fe++;
        end
        bits_q.delete();
    endtask

    task automatic model_clear();
        bits_q.delete();
        m_data = '0;
        m_ovr  = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        seg_sout = b;
        repeat (2) @(negedge clk);
        seg_clk = 1'b1;
        repeat (4) @(negedge clk);
        seg_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_bit(b);
    endtask

    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = 63; i > 63 - n; i--) send_bit(w[i]);
    endtask

    task automatic pulse_pen();
        SEG_PEN = 1'b1;
        repeat (4) @(negedge clk);
        SEG_PEN = 1'b0;
        repeat (4) @(negedge clk);
        model_commit();
    endtask

    initial begin
        logic [63:0] w;
        logic [6:0]  c0;
        int          len;
        rst = 1'b1; seg_clk = 1'b0; seg_sout = 1'b0; SEG_PEN = 1'b0; seg_clrn = 1'b1;
        m_data = '0; m_ovr = 1'b0; m_fv = 0; m_fe = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // Full frame
        send_word(64'h0123_4567_89AB_CDEF, 64);
        pulse_pen();
        check_all("full64");

        // Shift latency: bit_cnt moves exactly SS+1 edges after the pin edge
        seg_sout = 1'b1;
        @(negedge clk);
        c0 = bit_cnt;
        seg_clk = 1'b1;
        repeat (SS) @(posedge clk);
        #1 chk("lat.before", 64'(bit_cnt), 64'(c0));
        @(posedge clk);
        #1 chk("lat.after", 64'(bit_cnt), 64'(c0 + 7'd1));
        repeat (4) @(negedge clk);
        seg_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_bit(1'b1);
        send_word(64'h0, 39);
        pulse_pen();
        check_all("short40");

        // Overrun
        send_word(64'hFFFF_0000_FFFF_0000, 64);
        send_bit(1'b1);
        send_bit(1'b0);
        check_all("ovr.pre");
        pulse_pen();
        check_all("ovr66");

        // Clear for 4 cycles
        seg_clrn = 1'b0;
        repeat (4) @(negedge clk);
        seg_clrn = 1'b1;
        model_clear();
        check_all("clrn");

        // Coincident commit and 64th edge
        send_word(64'h1234_5678_9ABC_DEF0, 64);
        pulse_pen();
        send_word(64'h0F0F_0F0F_0F0F_0F0F, 63);
        seg_sout = 1'b1;
        repeat (2) @(negedge clk);
        seg_clk = 1'b1;
        SEG_PEN = 1'b1;
        repeat (4) @(negedge clk);
        seg_clk = 1'b0;
        SEG_PEN = 1'b0;
        repeat (4) @(negedge clk);
        model_commit();
        check_all("coincide");

        // Reset mid-frame
        send_word(64'hDEAD_BEEF_0000_0000, 20);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_all("rst.mid");
        send_word(64'hA5A5_A5A5_5A5A_5A5A, 64);
        pulse_pen();
        check_all("after.rst");

        // Random frames of assorted lengths
        for (int f = 0; f < 6; f++) begin
            w = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       len = 64;
                1:       len = $urandom_range(1, 63);
                default: len = 64 + $urandom_range(1, 3);
            endcase
            send_word(w, (len > 64) ? 64 : len);
            for (int k = 64; k < len; k++) send_bit(1'($urandom));
            pulse_pen();
            check_all("rand");
        end

        chk("exclusive", 64'(both_seen), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
